// File: rtl/down_counter_sched_if.sv
// down_counter_sched_if: request/grant and shared-counter signals between requesters, scheduler and counter
interface down_counter_sched_if #(parameter int WIDTH = 8);
    logic [2:0]       req;
    logic [2:0]       gnt;
    logic [2:0]       done;
    logic [WIDTH-1:0] dly0;
    logic [WIDTH-1:0] dly1;
    logic [WIDTH-1:0] dly2;
    logic [WIDTH-1:0] cnt_pi;
    logic             busy;
    logic             cnt_ld;
    logic             cnt_en;
    logic             cnt_co;
    modport slave (input req, dly0, dly1, dly2, cnt_co, output gnt, done, busy, cnt_ld, cnt_en, cnt_pi);
    modport master (output req, dly0, dly1, dly2, cnt_co, input gnt, done, busy, cnt_ld, cnt_en, cnt_pi);
endinterface

// File: rtl/down_counter_sched.sv
// down_counter_sched: round-robin arbiter sharing one down counter among three delay requesters
module down_counter_sched #(parameter int WIDTH = 8) (
    input logic                clk,
    input logic                rst,
    down_counter_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [1:0]       rr_ptr, gnt_idx, win_idx, p1, p2;
    logic [2:0]       gnt_q;
    logic [WIDTH-1:0] dly_q, win_dly;
    // pick the first requester at or after rr_ptr, wrapping 0->1->2->0
    always_comb begin
        p1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        p2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
        win_idx = bus.req[rr_ptr] ? rr_ptr : bus.req[p1] ? p1 : p2;
        win_dly = (win_idx == 2'd0) ? bus.dly0 : (win_idx == 2'd1) ? bus.dly1 : bus.dly2;
    end
    // next-state: one LOAD cycle, RUN until carry-out, one DONE cycle
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? ((|bus.req) ? LOAD : IDLE) :
                  (state == LOAD) ? RUN :
                  (state == RUN)  ? (bus.cnt_co ? DONE : RUN) : IDLE;
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end
    // grant/delay capture on acceptance, pointer rotation and grant release on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= 2'd0;
            gnt_idx <= 2'd0;
            gnt_q   <= 3'b000;
            dly_q   <= '0;
        end else if (state == IDLE && |bus.req) begin
            gnt_idx <= win_idx;
            gnt_q   <= 3'b001 << win_idx;
            dly_q   <= win_dly;
        end else if (state == DONE) begin
            rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            gnt_q  <= 3'b000;
        end
    end
    assign bus.gnt    = gnt_q;
    assign bus.done   = (state == DONE) ? gnt_q : 3'b000;
    assign bus.busy   = state != IDLE;
    assign bus.cnt_ld = state == LOAD;
    assign bus.cnt_en = state == RUN;
    assign bus.cnt_pi = dly_q;
endmodule

// File: tb/tb_down_counter_sched.sv
// tb_down_counter_sched: directed checks of the scheduler driving a behavioural shared down counter
module tb_down_counter_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int passed = 0;
    logic [7:0] cnt_q;

    down_counter_sched_if #(.WIDTH(8)) bus();
    down_counter_sched #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // external 8-bit down counter: ld wins over dcen, CO while count==0 and enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 8'd0;
        else if (bus.cnt_ld) cnt_q <= bus.cnt_pi;
        else if (bus.cnt_en) cnt_q <= cnt_q - 8'd1;
    end
    assign bus.cnt_co = bus.cnt_en && (cnt_q == 8'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req = 3'b000;
        bus.dly0 = 8'd0;
        bus.dly1 = 8'd0;
        bus.dly2 = 8'd0;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ld", 32'(bus.cnt_ld), 0);
        chk("rst_en", 32'(bus.cnt_en), 0);
        chk("rst_pi", 32'(bus.cnt_pi), 0);
        rst = 1'b1;
        // single request, D=10
        bus.req = 3'b001;
        bus.dly0 = 8'd10;
        chk("t1_idle_busy", 32'(bus.busy), 0);
        step();
        chk("t1_gnt", 32'(bus.gnt), 1);
        chk("t1_ld", 32'(bus.cnt_ld), 1);
        chk("t1_pi", 32'(bus.cnt_pi), 10);
        chk("t1_load_en", 32'(bus.cnt_en), 0);
        for (int k = 0; k < 11; k++) begin
            step();
            chk("t1_run_en", 32'(bus.cnt_en), 1);
            chk("t1_run_done", 32'(bus.done), 0);
            chk("t1_run_ld", 32'(bus.cnt_ld), 0);
        end
        step();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_done_en", 32'(bus.cnt_en), 0);
        bus.req = 3'b000;
        step();
        chk("t1_after_busy", 32'(bus.busy), 0);
        chk("t1_after_gnt", 32'(bus.gnt), 0);
        chk("t1_after_done", 32'(bus.done), 0);
        // three simultaneous requests, D=3 each
        do_reset();
        bus.dly0 = 8'd3;
        bus.dly1 = 8'd3;
        bus.dly2 = 8'd3;
        bus.req = 3'b111;
        step();
        chk("t2_gnt0", 32'(bus.gnt), 1);
        repeat (4) step();
        chk("t2_pre_done0", 32'(bus.done), 0);
        step();
        chk("t2_done0", 32'(bus.done), 1);
        bus.req = 3'b110;
        step();
        chk("t2_gap0_busy", 32'(bus.busy), 0);
        chk("t2_gap0_gnt", 32'(bus.gnt), 0);
        step();
        chk("t2_gnt1", 32'(bus.gnt), 2);
        repeat (5) step();
        chk("t2_done1", 32'(bus.done), 2);
        bus.req = 3'b100;
        step();
        chk("t2_gap1_busy", 32'(bus.busy), 0);
        step();
        chk("t2_gnt2", 32'(bus.gnt), 4);
        repeat (5) step();
        chk("t2_done2", 32'(bus.done), 4);
        bus.req = 3'b000;
        step();
        chk("t2_end_busy", 32'(bus.busy), 0);
        // fairness: requester 0 keeps asking while 1 waits
        do_reset();
        bus.dly0 = 8'd2;
        bus.dly1 = 8'd2;
        bus.req = 3'b011;
        step();
        chk("t3_gnt0", 32'(bus.gnt), 1);
        repeat (4) step();
        chk("t3_done0", 32'(bus.done), 1);
        step();
        chk("t3_gap_busy", 32'(bus.busy), 0);
        step();
        chk("t3_gnt1", 32'(bus.gnt), 2);
        repeat (4) step();
        chk("t3_done1", 32'(bus.done), 2);
        bus.req = 3'b000;
        step();
        // zero delay
        bus.dly1 = 8'd0;
        bus.req = 3'b010;
        step();
        chk("t4_gnt", 32'(bus.gnt), 2);
        chk("t4_pi", 32'(bus.cnt_pi), 0);
        step();
        chk("t4_run_en", 32'(bus.cnt_en), 1);
        chk("t4_run_done", 32'(bus.done), 0);
        step();
        chk("t4_done", 32'(bus.done), 2);
        chk("t4_done_en", 32'(bus.cnt_en), 0);
        bus.req = 3'b000;
        step();
        chk("t4_end_busy", 32'(bus.busy), 0);
        // reset in the middle of a run
        do_reset();
        bus.dly2 = 8'd20;
        bus.req = 3'b100;
        repeat (8) step();
        chk("t5_pre_en", 32'(bus.cnt_en), 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(bus.gnt), 0);
        chk("t5_rst_busy", 32'(bus.busy), 0);
        chk("t5_rst_en", 32'(bus.cnt_en), 0);
        chk("t5_rst_ld", 32'(bus.cnt_ld), 0);
        chk("t5_rst_pi", 32'(bus.cnt_pi), 0);
        chk("t5_rst_done", 32'(bus.done), 0);
        step();
        chk("t5_held_done", 32'(bus.done), 0);
        chk("t5_held_busy", 32'(bus.busy), 0);
        rst = 1'b1;
        bus.dly1 = 8'd1;
        bus.req = 3'b110;
        step();
        chk("t5_gnt", 32'(bus.gnt), 2);
        repeat (3) step();
        chk("t5_done", 32'(bus.done), 2);
        bus.req = 3'b000;
        step();
        // inputs changing after grant are ignored
        bus.dly0 = 8'd5;
        bus.req = 3'b001;
        step();
        chk("t6_gnt", 32'(bus.gnt), 1);
        chk("t6_pi_load", 32'(bus.cnt_pi), 5);
        step();
        chk("t6_pi_run0", 32'(bus.cnt_pi), 5);
        step();
        bus.dly0 = 8'd50;
        bus.req = 3'b000;
        chk("t6_pi_run1", 32'(bus.cnt_pi), 5);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_pi_run", 32'(bus.cnt_pi), 5);
            chk("t6_run_done", 32'(bus.done), 0);
        end
        step();
        chk("t6_done", 32'(bus.done), 1);
        chk("t6_done_pi", 32'(bus.cnt_pi), 5);
        step();
        chk("t6_idle_busy", 32'(bus.busy), 0);
        step();
        chk("t6_stay_idle", 32'(bus.busy), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
